// File: rtl/matrix_pkg.sv
// Shared types and width helpers for the matrix stream buffer and its benches.
package matrix_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } mxb_state_e;

  localparam int ELEM_DW = 32;
  typedef logic [ELEM_DW-1:0] elem_t;

  // An index into n positions needs at least one bit, even when n is 1.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int row_w(input int rows);
    return idx_width(rows);
  endfunction

  function automatic int col_w(input int cols);
    return idx_width(cols);
  endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// Two-dimensional (row, col) index walker, stepping row-major or column-major.
module matrix_index_counter
  import matrix_pkg::*;
#(
  parameter int ROWS = 2,
  parameter int COLS = 3,
  parameter int RW   = row_w(ROWS),
  parameter int CW   = col_w(COLS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          col_major,
  input  logic          clr,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last
);

  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

  logic [RW-1:0] row_reg, row_next;
  logic [CW-1:0] col_reg, col_next;
  logic          row_at_max, col_at_max;

  assign row_at_max = (row_reg == ROW_MAX);
  assign col_at_max = (col_reg == COL_MAX);

  // The final position wraps to (0,0) in both orders, so a frame ends cleanly even without clr.
  always_comb begin
    row_next = row_reg;
    col_next = col_reg;
    if (clr) begin
      row_next = '0;
      col_next = '0;
    end else if (en) begin
      if (col_major) begin
        if (row_at_max) begin
          row_next = '0;
          col_next = col_at_max ? '0 : col_reg + 1'b1;
        end else begin
          row_next = row_reg + 1'b1;
        end
      end else begin
        if (col_at_max) begin
          col_next = '0;
          row_next = row_at_max ? '0 : row_reg + 1'b1;
        end else begin
          col_next = col_reg + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_reg <= '0;
      col_reg <= '0;
    end else begin
      row_reg <= row_next;
      col_reg <= col_next;
    end
  end

  assign row  = row_reg;
  assign col  = col_reg;
  assign last = row_at_max && col_at_max;

endmodule

// File: rtl/matrix_stream_buffer.sv
// Captures a row-major frame into a register matrix, then replays it as
// (row, col, value) beats in row-major or transposed order.
module matrix_stream_buffer
  import matrix_pkg::*;
#(
  parameter int ROWS = 2,
  parameter int COLS = 3,
  parameter int DW   = 32,
  parameter int RW   = row_w(ROWS),
  parameter int CW   = col_w(COLS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          transpose,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [RW-1:0] out_row,
  output logic [CW-1:0] out_col,
  output logic          out_last,
  output logic          busy
);

  localparam int N  = ROWS * COLS;
  localparam int IW = idx_width(N);

  mxb_state_e    state_reg, state_next;
  logic          mode_reg, mode_next;
  logic [DW-1:0] mem [N];

  logic [RW-1:0] wr_row, rd_row;
  logic [CW-1:0] wr_col, rd_col;
  logic          wr_last, rd_last;
  logic          wr_fire, rd_fire, wr_first;
  logic [IW-1:0] wr_idx, rd_idx;
  logic [N-1:0]  wr_sel;

  assign wr_fire  = in_valid && (state_reg == FILL);
  assign rd_fire  = out_ready && (state_reg == DRAIN);
  assign wr_first = (wr_row == '0) && (wr_col == '0);

  matrix_index_counter #(.ROWS(ROWS), .COLS(COLS), .RW(RW), .CW(CW)) u_wr_idx (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (wr_fire),
    .col_major (1'b0),
    .clr       (wr_fire && wr_last),
    .row       (wr_row),
    .col       (wr_col),
    .last      (wr_last)
  );

  matrix_index_counter #(.ROWS(ROWS), .COLS(COLS), .RW(RW), .CW(CW)) u_rd_idx (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (rd_fire),
    .col_major (mode_reg),
    .clr       (rd_fire && rd_last),
    .row       (rd_row),
    .col       (rd_col),
    .last      (rd_last)
  );

  // Whenever COLS does not fit in IW bits the matrix is a single row, so the product is zero anyway.
  assign wr_idx = IW'(wr_row) * IW'(COLS) + IW'(wr_col);
  assign rd_idx = IW'(rd_row) * IW'(COLS) + IW'(rd_col);

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_wr_sel
      assign wr_sel[gi] = wr_fire && (wr_idx == IW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (wr_sel[i]) mem[i] <= in_data;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    mode_next  = mode_reg;
    case (state_reg)
      FILL: begin
        if (wr_fire && wr_first) mode_next = transpose;
        if (wr_fire && wr_last)  state_next = DRAIN;
      end
      DRAIN: begin
        if (rd_fire && rd_last) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= FILL;
      mode_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      mode_reg  <= mode_next;
    end
  end

  assign in_ready  = (state_reg == FILL);
  assign out_valid = (state_reg == DRAIN);
  assign out_data  = out_valid ? mem[rd_idx] : '0;
  assign out_row   = rd_row;
  assign out_col   = rd_col;
  assign out_last  = out_valid && rd_last;
  assign busy      = (state_reg == DRAIN) || !wr_first;

endmodule
